// File: rtl/soc_memio.sv
// Memory and IO block for a small soft CPU: byte-masked word RAM, an LED register
// and a fixed-baud 8N1 UART transmitter. All outputs are registered.
module soc_memio #(
  parameter int RAM_WORDS = 1024,
  parameter int CLK_DIV   = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_rstrb,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic [7:0]  leds
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [31:0] ram [0:RAM_WORDS-1] = '{default: 32'h0};

  logic          is_io;
  logic [AW-1:0] word_idx;
  logic [2:0]    io_sel;
  logic          wr_any;
  logic          uart_we;
  logic          busy;
  logic [31:0]   io_rdata;
  logic          unused_addr_bits;

  uart_state_t   state, state_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, idx_next;
  logic [7:0]    tx_byte, byte_next;
  logic          tx_next;
  logic          baud_last;

  assign is_io    = mem_addr[22];
  assign word_idx = mem_addr[AW+1:2];
  assign io_sel   = mem_addr[4:2];
  assign wr_any   = |mem_wmask;
  assign busy     = (state != IDLE);
  // Writes arriving while a frame is in flight (including its final STOP edge) are dropped.
  assign uart_we  = is_io && wr_any && (io_sel == 3'd1) && (state == IDLE);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign unused_addr_bits = ^{mem_addr[31:23], mem_addr[21:AW+2], mem_addr[1:0]};

  always_comb begin
    io_rdata = 32'h0;
    case (io_sel)
      3'd0:    io_rdata = {24'h0, leds};
      3'd2:    io_rdata = {31'h0, busy};
      default: io_rdata = 32'h0;
    endcase
  end

  // RAM is never cleared by reset, but reset still blocks a coincident write.
  always_ff @(posedge clk) begin
    if (!rst && !is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= 32'h0;
      leds      <= 8'h0;
    end else begin
      if (mem_rstrb) mem_rdata <= is_io ? io_rdata : ram[word_idx];
      if (is_io && wr_any && (io_sel == 3'd0)) leds <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      tx_byte  <= 8'h0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= idx_next;
      tx_byte  <= byte_next;
      uart_tx  <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    idx_next   = bit_idx;
    byte_next  = tx_byte;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (uart_we) begin
          state_next = START;
          baud_next  = '0;
          byte_next  = mem_wdata[7:0];
        end
      end
      START: begin
        if (baud_last) begin
          state_next = DATA;
          baud_next  = '0;
          idx_next   = 3'd0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 idx_next   = bit_idx + 3'd1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          state_next = IDLE;
          baud_next  = '0;
          idx_next   = 3'd0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // The line level is computed from the next state so uart_tx stays a plain register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = byte_next[idx_next];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_soc_memio.sv
// Directed self-checking bench for soc_memio: RAM lanes, LED/status IO and UART framing.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_soc_memio;

  localparam int RAM_WORDS = 64;
  localparam int CLK_DIV   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic [7:0]  leds;

  int checks   = 0;
  int failures = 0;

  soc_memio #(.RAM_WORDS(RAM_WORDS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rstrb(mem_rstrb),
    .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata),
    .uart_tx(uart_tx),
    .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask, input logic rstrb);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wmask = wmask;
    mem_rstrb = rstrb;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called right after the edge that accepted the UART write. Polls status each cycle
  // (except when injecting a competing write), then checks the line stays quiet.
  task automatic checkFrame(input string name, input logic [7:0] value, input int inject_at);
    logic [9:0] frame;
    int busy_cnt;
    int low_cnt;
    frame    = {1'b1, value, 1'b0};
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      checkOutput($sformatf("%s_tx%0d", name, i), {31'h0, uart_tx}, {31'h0, frame[i/4]});
      if (i == inject_at) applyStimulus(32'h0040_0004, 32'h0000_00FF, 4'b0001, 1'b0);
      else                applyStimulus(32'h0040_0008, 32'h0, 4'b0000, 1'b1);
      busy_cnt += int'(mem_rdata[0]);
    end
    checkOutput({name, "_idle_tx"}, {31'h0, uart_tx}, 32'h1);
    applyStimulus(32'h0040_0008, 32'h0, 4'b0000, 1'b1);
    checkOutput({name, "_busy_clear"}, mem_rdata, 32'h0);
    if (inject_at < 0) checkOutput({name, "_busy_cycles"}, busy_cnt, 32'd40);
    low_cnt = 0;
    for (int i = 0; i < 44; i++) begin
      applyStimulus(32'h0040_0008, 32'h0, 4'b0000, 1'b1);
      low_cnt += int'(!uart_tx);
    end
    checkOutput({name, "_no_second_frame"}, low_cnt, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_wmask = 4'h0; mem_rstrb = 1'b0;

    // Reset held while writing the LED register and reading it: reset must win.
    applyStimulus(32'h0040_0000, 32'h0000_00FF, 4'b0001, 1'b1);
    applyStimulus(32'h0040_0000, 32'h0000_00FF, 4'b0001, 1'b1);
    rst = 1'b0;
    checkOutput("reset_rdata", mem_rdata, 32'h0);
    checkOutput("reset_leds", {24'h0, leds}, 32'h0);
    checkOutput("reset_tx", {31'h0, uart_tx}, 32'h1);

    // Byte-lane writes and one-cycle read latency.
    applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    applyStimulus(32'h0000_0010, 32'h00AA_0000, 4'b0100, 1'b0);
    applyStimulus(32'h0000_0010, 32'h0, 4'b0000, 1'b1);
    checkOutput("ram_lane_merge", mem_rdata, 32'hDEAA_BEEF);
    applyStimulus(32'h0000_0000, 32'h0, 4'b0000, 1'b0);
    checkOutput("rdata_hold", mem_rdata, 32'hDEAA_BEEF);

    // LED register uses wdata[7:0] only; unmapped offsets read 0 and ignore writes.
    applyStimulus(32'h0040_0000, 32'h1234_565A, 4'b0001, 1'b0);
    checkOutput("led_write", {24'h0, leds}, 32'h5A);
    applyStimulus(32'h0040_0000, 32'h0, 4'b0000, 1'b1);
    checkOutput("led_read", mem_rdata, 32'h0000_005A);
    applyStimulus(32'h0040_001C, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    checkOutput("io_unmapped_read", mem_rdata, 32'h0);
    checkOutput("io_unmapped_write", {24'h0, leds}, 32'h5A);
    applyStimulus(32'h0040_0008, 32'h0, 4'b0000, 1'b1);
    checkOutput("status_idle", mem_rdata, 32'h0);

    // Plain frame, frame with a mid-frame write, frame with a write on the final STOP edge.
    applyStimulus(32'h0040_0004, 32'h0000_00A5, 4'b0001, 1'b0);
    checkFrame("frameA5", 8'hA5, -1);
    applyStimulus(32'h0040_0004, 32'h0000_00A5, 4'b0001, 1'b0);
    checkFrame("frameA5_drop", 8'hA5, 8);
    applyStimulus(32'h0040_0004, 32'h0000_003C, 4'b0001, 1'b0);
    checkFrame("frame3C_stopedge", 8'h3C, 39);

    // Reset in the middle of a frame, then a clean frame afterwards.
    applyStimulus(32'h0040_0004, 32'h0000_003C, 4'b0001, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0);
    rst = 1'b1;
    applyStimulus(32'h0040_0008, 32'h0, 4'b0000, 1'b1);
    rst = 1'b0;
    checkOutput("abort_tx", {31'h0, uart_tx}, 32'h1);
    checkOutput("abort_rdata", mem_rdata, 32'h0);
    checkOutput("abort_leds", {24'h0, leds}, 32'h0);
    applyStimulus(32'h0040_0008, 32'h0, 4'b0000, 1'b1);
    checkOutput("abort_status", mem_rdata, 32'h0);
    applyStimulus(32'h0040_0004, 32'h0000_0001, 4'b0001, 1'b0);
    checkFrame("frame01", 8'h01, -1);

    // Read-during-write returns old data; aliasing above the RAM size; RAM survives reset.
    applyStimulus(32'h0000_0020, 32'h1111_1111, 4'b1111, 1'b1);
    checkOutput("rdw_old_value", mem_rdata, 32'h0);
    applyStimulus(32'h0000_0020, 32'h0, 4'b0000, 1'b1);
    checkOutput("rdw_new_value", mem_rdata, 32'h1111_1111);
    applyStimulus(32'h0000_0000, 32'h0, 4'b0000, 1'b1);
    checkOutput("word0_zero", mem_rdata, 32'h0);
    applyStimulus(32'h0000_0020 + 4*RAM_WORDS, 32'h0, 4'b0000, 1'b1);
    checkOutput("ram_alias", mem_rdata, 32'h1111_1111);
    applyStimulus(32'h0000_0010, 32'h0, 4'b0000, 1'b1);
    checkOutput("ram_after_reset", mem_rdata, 32'hDEAA_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
